// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: buffered entry layout and fetch stride.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {pc, instr} entries between the instruction bus and decode.
// Flush has priority over push/pop and empties the buffer in one edge.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fetch_entry_t                 i_data,
  output fetch_entry_t                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch front end: owns the fetch PC, issues sequential bus reads, buffers words for decode.
// Optional macro FETCH_BYPASS_EN forwards a bus word straight to decode when the buffer is empty.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] instr_address_out,
  output logic        instr_read_out,
  input  logic [31:0] instr_read_value_in,
  input  logic        instr_ready_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        fetch_valid_out,
  output logic [31:0] fetch_pc_out,
  output logic [31:0] fetch_instr_out,
  input  logic        fetch_ready_in
);

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   r_pc;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push_bus;
  logic          w_fifo_push;
  logic          w_fifo_pop;
  fetch_entry_t  w_bus_entry;
  fetch_entry_t  w_head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC & ~32'd3;
    end else if (redirect_in) begin
      r_pc <= redirect_pc_in & ~32'd3;
    end else if (w_push_bus) begin
      r_pc <= r_pc + 32'(INSTR_BYTES);
    end
  end

  assign w_full  = (w_count == CW'(DEPTH));
  assign w_empty = (w_count == '0);

  // A full buffer blocks the request even if decode frees a slot this cycle.
  assign instr_address_out = r_pc;
  assign instr_read_out    = reset_n & ~redirect_in & ~w_full;
  assign w_push_bus        = instr_read_out & instr_ready_in;

  assign w_bus_entry.pc    = r_pc;
  assign w_bus_entry.instr = instr_read_value_in;

`ifdef FETCH_BYPASS_EN
  logic w_bypass;

  assign w_bypass        = w_empty & w_push_bus;
  assign fetch_valid_out = reset_n & ~redirect_in & (~w_empty | w_push_bus);
  assign fetch_pc_out    = w_bypass ? w_bus_entry.pc    : w_head.pc;
  assign fetch_instr_out = w_bypass ? w_bus_entry.instr : w_head.instr;
  // A bypassed word consumed by decode never occupies a slot.
  assign w_fifo_push     = w_push_bus & ~(w_bypass & fetch_ready_in);
`else
  assign fetch_valid_out = reset_n & ~redirect_in & ~w_empty;
  assign fetch_pc_out    = w_head.pc;
  assign fetch_instr_out = w_head.instr;
  assign w_fifo_push     = w_push_bus;
`endif

  assign w_fifo_pop = fetch_valid_out & fetch_ready_in & ~w_empty;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_flush (redirect_in),
    .i_data  (w_bus_entry),
    .o_data  (w_head),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: scoreboard of bus hits vs decode handshakes plus directed cycle checks.
module tb_instr_fetch_buffer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic [31:0] instr_read_value_in;
  logic        instr_ready_in = 1'b0;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc_in = 32'h0;
  logic        fetch_valid_out;
  logic [31:0] fetch_pc_out;
  logic [31:0] fetch_instr_out;
  logic        fetch_ready_in = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  ent_t        q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  // Bus memory model: each word is a scrambled copy of its address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  assign instr_read_value_in = word_of(instr_address_out);

  instr_fetch_buffer #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .instr_address_out   (instr_address_out),
    .instr_read_out      (instr_read_out),
    .instr_read_value_in (instr_read_value_in),
    .instr_ready_in      (instr_ready_in),
    .redirect_in         (redirect_in),
    .redirect_pc_in      (redirect_pc_in),
    .fetch_valid_out     (fetch_valid_out),
    .fetch_pc_out        (fetch_pc_out),
    .fetch_instr_out     (fetch_instr_out),
    .fetch_ready_in      (fetch_ready_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: bus hits push expected entries, decode handshakes pop and compare.
  always @(negedge clk) begin
    ent_t e;
    if (!reset_n) begin
      chk1("mon_rst_read", instr_read_out, 1'b0);
      chk1("mon_rst_valid", fetch_valid_out, 1'b0);
      q.delete();
      exp_pc = RST_PC & ~32'd3;
    end else if (redirect_in) begin
      chk1("redir_no_read", instr_read_out, 1'b0);
      chk1("redir_no_valid", fetch_valid_out, 1'b0);
      q.delete();
      exp_pc = redirect_pc_in & ~32'd3;
    end else begin
      if (instr_read_out) chk("bus_addr", instr_address_out, exp_pc);
      if (instr_read_out && instr_ready_in) begin
        q.push_back(ent_t'{exp_pc, word_of(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      if (fetch_valid_out && fetch_ready_in) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: pc %h presented with nothing expected", fetch_pc_out);
        end else begin
          e = q.pop_front();
          chk("out_pc", fetch_pc_out, e.pc);
          chk("out_instr", fetch_instr_out, e.instr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset mid-cycle: outputs must drop before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("async_rst_read", instr_read_out, 1'b0);
    chk1("async_rst_valid", fetch_valid_out, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk1("rst_read", instr_read_out, 1'b0);
    chk1("rst_valid", fetch_valid_out, 1'b0);
    chk("rst_addr", instr_address_out, 32'h100);

    // 1: streaming with ready bus and ready decode
    instr_ready_in = 1'b1;
    fetch_ready_in = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk1("t1_read", instr_read_out, 1'b1);
    chk("t1_addr0", instr_address_out, 32'h100);
    chk1("t1_latency", fetch_valid_out, BYP);
    tick();
    @(negedge clk);
    chk("t1_addr1", instr_address_out, 32'h104);
    chk1("t1_valid1", fetch_valid_out, 1'b1);
    chk("t1_pc1", fetch_pc_out, BYP ? 32'h104 : 32'h100);
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    chk1("t1_valid_steady", fetch_valid_out, 1'b1);

    // 2: decode stalled after reset, buffer fills, then drains in order
    tick();
    fetch_ready_in = 1'b0;
    do_reset();
    @(negedge clk);
    chk("t2_addr0", instr_address_out, 32'h100);
    tick();
    @(negedge clk);
    chk1("t2_read1", instr_read_out, 1'b1);
    chk("t2_addr1", instr_address_out, 32'h104);
    tick();
    @(negedge clk);
    chk1("t2_full_noread", instr_read_out, 1'b0);
    chk("t2_head", fetch_pc_out, 32'h100);
    tick();
    fetch_ready_in = 1'b1;
    @(negedge clk);
    chk1("t2_full_pop_noread", instr_read_out, 1'b0);
    chk1("t2_valid", fetch_valid_out, 1'b1);
    tick();
    @(negedge clk);
    chk1("t2_refill_read", instr_read_out, 1'b1);
    chk("t2_refill_addr", instr_address_out, 32'h108);
    chk("t2_second", fetch_pc_out, 32'h104);
    for (int i = 0; i < 3; i++) tick();

    // 3: bus stall holds the PC
    do_reset();
    @(negedge clk);
    chk("t3_addr0", instr_address_out, 32'h100);
    tick();
    instr_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_addr", instr_address_out, 32'h104);
      chk1("t3_stall_read", instr_read_out, 1'b1);
      if (i == 2) chk1("t3_stall_empty", fetch_valid_out, 1'b0);
      tick();
    end
    instr_ready_in = 1'b1;
    @(negedge clk);
    chk("t3_resume_addr", instr_address_out, 32'h104);
    tick();
    @(negedge clk);
    chk("t3_next_addr", instr_address_out, 32'h108);
    tick();

    // 4: redirect with two stale entries buffered
    fetch_ready_in = 1'b0;
    do_reset();
    tick();
    tick();
    redirect_in    = 1'b1;
    redirect_pc_in = 32'h2003;
    fetch_ready_in = 1'b1;
    @(negedge clk);
    chk1("t4_redir_valid", fetch_valid_out, 1'b0);
    chk1("t4_redir_read", instr_read_out, 1'b0);
    tick();
    redirect_in = 1'b0;
    @(negedge clk);
    chk1("t4_read", instr_read_out, 1'b1);
    chk("t4_addr", instr_address_out, 32'h2000);
    chk1("t4_valid", fetch_valid_out, BYP);
    tick();
    @(negedge clk);
    chk1("t4_valid_next", fetch_valid_out, 1'b1);
    chk("t4_pc_next", fetch_pc_out, BYP ? 32'h2004 : 32'h2000);
    for (int i = 0; i < 3; i++) tick();

    // 5: PC wrap at the top of the address space
    redirect_in    = 1'b1;
    redirect_pc_in = 32'hFFFF_FFFE;
    fetch_ready_in = 1'b0;
    tick();
    redirect_in = 1'b0;
    @(negedge clk);
    chk("t5_addr_top", instr_address_out, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    chk("t5_addr_wrap", instr_address_out, 32'h0000_0000);
    chk1("t5_valid", fetch_valid_out, 1'b1);
    chk("t5_pc_out", fetch_pc_out, 32'hFFFF_FFFC);
    tick();
    fetch_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // 6: final mid-stream reset then restart from RESET_PC
    do_reset();
    @(negedge clk);
    chk("t6_restart_addr", instr_address_out, 32'h100);
    chk1("t6_latency", fetch_valid_out, BYP);
    for (int i = 0; i < 4; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
